// File: rtl/cordic_post_fixup_if.sv
// ============================================================================
// Module      : cordic_post_fixup_if
// Description : Valid/ready result stream leaving cordic_post_fixup.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cordic_post_fixup_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEG_OUT_WIDTH = 17
);
    logic [DEG_OUT_WIDTH-1:0] degree_out;
    logic [DATA_WIDTH-1:0]    x_out;
    logic [DATA_WIDTH-1:0]    y_out;
    logic                     arctan_en_out;
    logic                     valid_out;
    logic                     ready_out;

    modport master (
        output degree_out, x_out, y_out, arctan_en_out, valid_out,
        input  ready_out
    );

    modport slave (
        input  degree_out, x_out, y_out, arctan_en_out, valid_out,
        output ready_out
    );
endinterface

`default_nettype wire

// File: rtl/cordic_post_fixup.sv
// ============================================================================
// Module      : cordic_post_fixup
// Description : Undoes CORDIC quadrant folding, widens the angle and buffers
//               results in a small FIFO that absorbs sink backpressure.
//               Optional macro CORDIC_POST_STATS_EN adds accept/drop counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cordic_post_fixup #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEG_IN_WIDTH    = 16,
    parameter int DEG_OUT_WIDTH   = 17,
    parameter int FRAC_WIDTH      = 8,
    parameter int FLIP_FLAG_WIDTH = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic [DEG_IN_WIDTH-1:0]       degree_in,
    input  wire logic [DATA_WIDTH-1:0]         x_in,
    input  wire logic [DATA_WIDTH-1:0]         y_in,
    input  wire logic [FLIP_FLAG_WIDTH-1:0]    flip_in,
    input  wire logic                          arctan_en_in,
    input  wire logic                          valid_in,
    input  wire logic                          clear_overflow,
    cordic_post_fixup_if.master                out_if,
    output logic                               overflow,
    output logic                               flip_err,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
`ifdef CORDIC_POST_STATS_EN
    ,
    output logic [15:0]                        accept_count,
    output logic [15:0]                        drop_count
`endif
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = 1 + DEG_OUT_WIDTH + 2 * DATA_WIDTH;
    localparam logic [DEG_OUT_WIDTH-1:0]   c_DEG_180  = DEG_OUT_WIDTH'(180 * (2 ** FRAC_WIDTH));
    localparam logic [c_PTR_W:0]           c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0]      c_DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]      c_DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [FLIP_FLAG_WIDTH-1:0] c_FLIP_POS = FLIP_FLAG_WIDTH'(1);
    localparam logic [FLIP_FLAG_WIDTH-1:0] c_FLIP_NEG = FLIP_FLAG_WIDTH'(2);
    localparam logic [FLIP_FLAG_WIDTH-1:0] c_FLIP_RSV = {FLIP_FLAG_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1: fold correction
    // ------------------------------------------------------------------
    logic [DEG_OUT_WIDTH-1:0] w_deg_ext;
    logic [DEG_OUT_WIDTH-1:0] w_deg_fix;
    logic [DATA_WIDTH-1:0]    w_x_neg;
    logic [DATA_WIDTH-1:0]    w_y_neg;
    logic [DATA_WIDTH-1:0]    w_x_fix;
    logic [DATA_WIDTH-1:0]    w_y_fix;
    logic [c_ENTRY_W-1:0]     w_fix_entry;

    logic                     r_s1_valid;
    logic [c_ENTRY_W-1:0]     r_s1_entry;
    logic                     r_flip_err;

    assign w_deg_ext = {{(DEG_OUT_WIDTH-DEG_IN_WIDTH){degree_in[DEG_IN_WIDTH-1]}}, degree_in};
    // The most negative value has no positive twin; clamp it to full scale.
    assign w_x_neg   = (x_in == c_DATA_MIN) ? c_DATA_MAX : -x_in;
    assign w_y_neg   = (y_in == c_DATA_MIN) ? c_DATA_MAX : -y_in;

    always_comb begin
        w_deg_fix = w_deg_ext;
        w_x_fix   = x_in;
        w_y_fix   = y_in;
        if (arctan_en_in) begin
            if (flip_in == c_FLIP_POS) begin
                w_deg_fix = w_deg_ext + c_DEG_180;
            end else if (flip_in == c_FLIP_NEG) begin
                w_deg_fix = w_deg_ext - c_DEG_180;
            end
        end else if ((flip_in == c_FLIP_POS) || (flip_in == c_FLIP_NEG)) begin
            w_x_fix = w_x_neg;
            w_y_fix = w_y_neg;
        end
    end

    assign w_fix_entry = {arctan_en_in, w_deg_fix, w_x_fix, w_y_fix};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_entry <= '0;
            r_flip_err <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_entry <= w_fix_entry;
                if (flip_in == c_FLIP_RSV) begin
                    r_flip_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_ENTRY_W-1:0] r_last;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_level;
    logic                 r_overflow;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);
    assign w_pop   = !w_empty && out_if.ready_out;
    assign w_drop  = r_s1_valid && w_full && !w_pop;
    assign w_push  = r_s1_valid && !w_drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_last     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= r_s1_entry;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_last <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // While empty, keep presenting the most recently popped sample.
    assign w_head = w_empty ? r_last : r_mem[r_rptr];

    assign {out_if.arctan_en_out, out_if.degree_out, out_if.x_out, out_if.y_out} = w_head;
    assign out_if.valid_out = !w_empty;
    assign overflow         = r_overflow;
    assign flip_err         = r_flip_err;
    assign fifo_level       = r_level;

`ifdef CORDIC_POST_STATS_EN
    logic [15:0] r_accept_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_accept_count <= '0;
            r_drop_count   <= '0;
        end else begin
            if (w_push && (r_accept_count != 16'hFFFF)) begin
                r_accept_count <= r_accept_count + 16'd1;
            end
            if (w_drop) begin
                r_drop_count <= clear_overflow ? 16'd1 :
                                (r_drop_count != 16'hFFFF) ? r_drop_count + 16'd1 : r_drop_count;
            end else if (clear_overflow) begin
                r_drop_count <= '0;
            end
        end
    end

    assign accept_count = r_accept_count;
    assign drop_count   = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cordic_post_fixup.sv
// ============================================================================
// Module      : tb_cordic_post_fixup
// Description : Self-checking bench for cordic_post_fixup against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cordic_post_fixup;

    typedef struct packed {
        logic        at;
        logic [16:0] deg;
        logic [15:0] x;
        logic [15:0] y;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] degree_in;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [1:0]  flip_in;
    logic        arctan_en_in;
    logic        valid_in;
    logic        clear_overflow;
    logic        overflow;
    logic        flip_err;
    logic [2:0]  fifo_level;
`ifdef CORDIC_POST_STATS_EN
    logic [15:0] accept_count;
    logic [15:0] drop_count;
`endif

    cordic_post_fixup_if #(.DATA_WIDTH(16), .DEG_OUT_WIDTH(17)) bus ();

    cordic_post_fixup dut (
        .clk            (clk),
        .reset          (reset),
        .degree_in      (degree_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .flip_in        (flip_in),
        .arctan_en_in   (arctan_en_in),
        .valid_in       (valid_in),
        .clear_overflow (clear_overflow),
        .out_if         (bus),
        .overflow       (overflow),
        .flip_err       (flip_err),
        .fifo_level     (fifo_level)
`ifdef CORDIC_POST_STATS_EN
        ,
        .accept_count   (accept_count),
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain arithmetic on angles/values plus a bounded queue.
    function automatic item_t model_fix(input logic [15:0] deg, input logic [15:0] x,
                                        input logic [15:0] y, input logic [1:0] flip,
                                        input logic at);
        item_t it;
        int d, xi, yi, f;
        d  = $signed(deg);
        xi = $signed(x);
        yi = $signed(y);
        f  = (flip == 2'd3) ? 0 : int'(flip);
        if (at) begin
            if (f == 1) d = d + 180 * 256;
            else if (f == 2) d = d - 180 * 256;
        end else if (f != 0) begin
            xi = -xi;
            yi = -yi;
            if (xi > 32767) xi = 32767;
            if (yi > 32767) yi = 32767;
        end
        it.at  = at;
        it.deg = d[16:0];
        it.x   = xi[15:0];
        it.y   = yi[15:0];
        return it;
    endfunction

    item_t q[$];
    item_t m_last;
    item_t m_s1;
    logic  m_s1_valid;
    logic  m_over;
    logic  m_ferr;

    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_last     = '0;
            m_s1       = '0;
            m_s1_valid = 1'b0;
            m_over     = 1'b0;
            m_ferr     = 1'b0;
        end else begin
            bit drop;
            if (q.size() > 0 && bus.ready_out) m_last = q.pop_front();
            drop = m_s1_valid && (q.size() == 4);
            if (m_s1_valid && !drop) q.push_back(m_s1);
            if (drop) m_over = 1'b1;
            else if (clear_overflow) m_over = 1'b0;
            m_s1_valid = valid_in;
            if (valid_in) begin
                m_s1 = model_fix(degree_in, x_in, y_in, flip_in, arctan_en_in);
                if (flip_in == 2'd3) m_ferr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            item_t e;
            e = (q.size() != 0) ? q[0] : m_last;
            check("valid_out",  {31'd0, bus.valid_out}, {31'd0, (q.size() != 0)});
            check("fifo_level", {29'd0, fifo_level}, q.size());
            check("overflow",   {31'd0, overflow}, {31'd0, m_over});
            check("flip_err",   {31'd0, flip_err}, {31'd0, m_ferr});
            check("degree_out", {15'd0, bus.degree_out}, {15'd0, e.deg});
            check("x_out",      {16'd0, bus.x_out}, {16'd0, e.x});
            check("y_out",      {16'd0, bus.y_out}, {16'd0, e.y});
            check("arctan_out", {31'd0, bus.arctan_en_out}, {31'd0, e.at});
        end
    end

    task automatic drive(input logic v, input logic at, input logic [1:0] fl,
                         input logic [15:0] d, input logic [15:0] x, input logic [15:0] y);
        valid_in     = v;
        arctan_en_in = at;
        flip_in      = fl;
        degree_in    = d;
        x_in         = x;
        y_in         = y;
        @(negedge clk);
        clear_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic flush();
        bus.ready_out = 1'b1;
        idle(7);
    endtask

    initial begin
        reset = 1'b0; bus.ready_out = 1'b0; clear_overflow = 1'b0;
        valid_in = 1'b0; arctan_en_in = 1'b0; flip_in = 2'd0;
        degree_in = '0; x_in = '0; y_in = '0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_data",  {bus.degree_out[15:0], bus.x_out}, 32'd0);
        check("rst_flags", {30'd0, overflow, flip_err}, 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;

        // Arctan correction: -32 deg with flip 01 becomes 148 deg.
        bus.ready_out = 1'b1;
        drive(1'b1, 1'b1, 2'd1, 16'hE000, 16'h1234, 16'h5678);
        idle(1);
        check("t1_valid", {31'd0, bus.valid_out}, 32'd1);
        check("t1_deg",   {15'd0, bus.degree_out}, 32'd37888);
        check("t1_xy",    {bus.x_out, bus.y_out}, 32'h1234_5678);

        // Rotation negate with saturation.
        drive(1'b1, 1'b0, 2'd2, 16'hF000, 16'h8000, 16'h0100);
        idle(1);
        check("t2_x",   {16'd0, bus.x_out}, 32'h7FFF);
        check("t2_y",   {16'd0, bus.y_out}, 32'hFF00);
        check("t2_deg", {15'd0, bus.degree_out}, 32'h1F000);
        flush();

        // Backpressure: six samples into a four-deep FIFO.
        bus.ready_out = 1'b0;
        for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 2'd0, 16'h0, 16'(i), 16'h0);
        idle(2);
        check("t3_level", {29'd0, fifo_level}, 32'd4);
        check("t3_ovf",   {31'd0, overflow}, 32'd1);
        check("t3_head1", {16'd0, bus.x_out}, 32'd1);
        bus.ready_out = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            check("t3_order", {16'd0, bus.x_out}, 32'(i));
        end
        idle(1);
        check("t3_empty", {31'd0, bus.valid_out}, 32'd0);
        check("t3_hold",  {16'd0, bus.x_out}, 32'd4);

        // Clear with no drop.
        clear_overflow = 1'b1;
        idle(1);
        check("t4_clear", {31'd0, overflow}, 32'd0);

        // Full with simultaneous push and pop.
        bus.ready_out = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'd0, 16'h0, 16'(16 + i), 16'h0);
        check("t4_full", {29'd0, fifo_level}, 32'd4);
        bus.ready_out = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 2'd0, 16'h0, 16'(32 + i), 16'h0);
            check("t4_level", {29'd0, fifo_level}, 32'd4);
            check("t4_noovf", {31'd0, overflow}, 32'd0);
        end
        flush();

        // Reserved flip code: angle left alone, sticky error.
        drive(1'b1, 1'b1, 2'd3, 16'h0A00, 16'h0011, 16'h0022);
        idle(1);
        check("t5_deg",  {15'd0, bus.degree_out}, 32'h00A00);
        check("t5_ferr", {31'd0, flip_err}, 32'd1);

        // Clear on the same edge as a drop: set wins.
        bus.ready_out = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 2'd0, 16'h0, 16'(48 + i), 16'h0);
        clear_overflow = 1'b1;
        idle(1);
        check("t5_setwin", {31'd0, overflow}, 32'd1);
        clear_overflow = 1'b1;
        idle(1);
        check("t5_clear", {31'd0, overflow}, 32'd0);
        flush();

        // Reset mid-stream at level 3.
        bus.ready_out = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'd1, 16'h0100, 16'(64 + i), 16'h0005);
        idle(1);
        check("t6_level3", {29'd0, fifo_level}, 32'd3);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("t6_valid", {31'd0, bus.valid_out}, 32'd0);
        check("t6_level", {29'd0, fifo_level}, 32'd0);
        check("t6_data",  {bus.x_out, bus.y_out}, 32'd0);
        check("t6_deg",   {15'd0, bus.degree_out}, 32'd0);
        check("t6_flags", {30'd0, overflow, flip_err}, 32'd0);
`ifdef CORDIC_POST_STATS_EN
        check("t6_stats", {accept_count, drop_count}, 32'd0);
`endif

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] rx;
            rx = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            bus.ready_out  = ($urandom_range(0, 2) != 0);
            clear_overflow = ($urandom_range(0, 19) == 0);
            reset          = ($urandom_range(0, 299) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
                  16'($urandom), rx, 16'($urandom));
        end
        reset = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
